internal_arbiter: RTL and testbench
===================================

INTERNAL_ARBITER -- requirements
Module: internal_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter MAX_BURST, default 4: maximum beats one grant may carry, legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 pkt_in  input  N_PORTS x t_if_internal  per-requester packets; fields valid, data[63:0], addr.
REQ-006 in_ready  output  N_PORTS  per-requester accept strobe.
REQ-007 pkt_out  output  t_if_internal  registered packet to the consumer.
REQ-008 out_ready  input  1  consumer accepts pkt_out this cycle.
REQ-009 grant_id  output  $clog2(N_PORTS)  index of the currently or last granted port.
REQ-010 busy  output  1  high while in GRANT or while pkt_out.valid is high.
REQ-011 pkt_count  output  32  count of packets delivered on pkt_out.

Function
REQ-012 Input transfer on port i: pkt_in[i].valid && in_ready[i]; output transfer: pkt_out.valid && out_ready.
REQ-013 in_ready[i] = (state==GRANT) && (grant_id==i) && (!pkt_out.valid || out_ready); all other ports 0.
REQ-014 At most one in_ready bit is high in any cycle.
REQ-015 An accepted beat appears on pkt_out exactly one cycle later, with data and addr unchanged.
REQ-016 While pkt_out.valid && !out_ready, every pkt_out field is held stable.
REQ-017 An output transfer with no new input transfer clears pkt_out.valid next cycle.
REQ-018 Simultaneous input and output transfer: pkt_out loads the new beat and valid stays 1. Full throughput is 1 beat/cycle.
REQ-019 FSM states: IDLE, GRANT.
REQ-020 IDLE: if any pkt_in[k].valid, pick the first valid port scanning last_grant+1 upward, modulo N_PORTS.
REQ-021 On that pick: load grant_id, clear beat_cnt, go to GRANT. No input transfer occurs in IDLE, so arbitration costs one cycle.
REQ-022 IDLE with no valid request: stay in IDLE; grant_id holds its value.
REQ-023 GRANT: each input transfer increments beat_cnt.
REQ-024 GRANT exits to IDLE on an input transfer with beat_cnt==MAX_BURST-1 (burst limit).
REQ-025 GRANT also exits to IDLE when in_ready[grant_id]==1 and pkt_in[grant_id].valid==0 (requester drained).
REQ-026 On every exit from GRANT, last_grant takes the value of grant_id.
REQ-027 While stalled (in_ready low due to out_ready==0), GRANT is held regardless of the requester's valid.
REQ-028 A waiting requester is granted within N_PORTS-1 other grants (round-robin fairness).
REQ-029 pkt_count increments by 1 on each output transfer and wraps from 2^32-1 to 0.

Reset
REQ-030 Reset assertion clears asynchronously; release is synchronised to clk by the integrating level.
REQ-031 Reset values: state=IDLE, pkt_out all fields 0, in_ready all 0, grant_id=0, beat_cnt=0, last_grant=N_PORTS-1 (first grant goes to port 0), pkt_count=0, busy=0.
REQ-032 Reset mid-burst discards any beat held in pkt_out. No partial-burst state survives reset.

Structure
REQ-033 t_if_internal stays in internal_pkg.
REQ-034 Enum t_arb_state {IDLE, GRANT} and the default constants ARB_N_PORTS=4 and ARB_MAX_BURST=4 are added to internal_pkg.
REQ-035 Sub-module rr_pick: combinational round-robin priority picker. Inputs: request vector and last_grant. Outputs: found flag and index. Instantiated once.
REQ-036 Target size: 120-400 lines of RTL including rr_pick.

Verification
REQ-037 Reset, then port 2 presents 1 beat (data=0x55, addr=7) with out_ready=1 -> in_ready[2] high in cycle 2 after valid; pkt_out.valid with data 0x55 one cycle later; pkt_count=1.
REQ-038 All 4 ports continuously valid, out_ready=1 -> grant order 0,1,2,3,0. Each grant carries exactly 4 beats, then 1 idle arbitration cycle; pkt_count=16 after 4 grants.
REQ-039 Port 1 streaming, out_ready held 0 for 5 cycles mid-burst -> pkt_out frozen and in_ready[1]=0 for those cycles. No beat is lost or duplicated; sequence 1..8 arrives in order.
REQ-040 Port 3 sends 2 beats then drops valid -> return to IDLE after the drain cycle; grant_id=3; next request from port 0 is granted ahead of port 3.
REQ-041 Reset asserted while pkt_out.valid=1 in GRANT -> all outputs take reset values immediately, without waiting for a clock edge; first grant after release goes to port 0.
REQ-042 pkt_count forced near wrap (0xFFFFFFFF) via 2^32-1 deliveries or backdoor -> next output transfer gives pkt_count=0.

Source files
------------

// File: rtl/internal_pkg.sv
// Shared types and default sizing for the internal packet arbiter.
package internal_pkg;

    localparam int ADDR_W        = 16;
    localparam int ARB_N_PORTS   = 4;
    localparam int ARB_MAX_BURST = 4;

    typedef struct packed {
        logic              valid;
        logic [63:0]       data;
        logic [ADDR_W-1:0] addr;
    } t_if_internal;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } t_arb_state;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = last;
        for (int off = 1; off <= N; off++) begin
            cand = (cand == IDX_W'(N - 1)) ? '0 : cand + 1'b1;
            if (req[cand] && !found) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/internal_arbiter.sv
// Round-robin burst arbiter: N requesters share one registered output with 1 beat/cycle throughput.
// state | meaning
// IDLE  | no owner; pick next requester after last_grant (one-cycle arbitration)
// GRANT | grant_id owns the output until it drains or hits MAX_BURST beats
module internal_arbiter
    import internal_pkg::*;
#(
    parameter int N_PORTS   = ARB_N_PORTS,
    parameter int MAX_BURST = ARB_MAX_BURST,
    localparam int IDX_W    = $clog2(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  t_if_internal [N_PORTS-1:0]  pkt_in,
    output logic [N_PORTS-1:0]          in_ready,
    output t_if_internal                pkt_out,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy,
    output logic [31:0]                 pkt_count
);

    localparam int BCW = $clog2(MAX_BURST + 1);

    t_arb_state         state_q, state_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    t_if_internal       pkt_out_q, pkt_out_d;
    logic [31:0]        pkt_count_q, pkt_count_d;

    logic [N_PORTS-1:0] req_vec;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    t_if_internal       granted_pkt;
    logic               can_accept;
    logic               in_xfer;
    logic               out_xfer;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            req_vec[i] = pkt_in[i].valid;
        end
    end

    rr_pick #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_vec),
        .last  (last_grant_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign granted_pkt = pkt_in[grant_id_q];
    // Output slot is free when empty or being drained this cycle.
    assign can_accept  = !pkt_out_q.valid || out_ready;
    assign in_xfer     = (state_q == GRANT) && can_accept && granted_pkt.valid;
    assign out_xfer    = pkt_out_q.valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDX_W'(N_PORTS - 1);
            beat_cnt_q   <= '0;
            pkt_out_q    <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_out_q    <= pkt_out_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                // A stall (can_accept low) freezes the grant whatever the requester does.
                if (can_accept) begin
                    if (!granted_pkt.valid || (beat_cnt_q == BCW'(MAX_BURST - 1))) begin
                        state_d      = IDLE;
                        last_grant_d = grant_id_q;
                    end
                    if (in_xfer) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_out_d = pkt_out_q;
        if (in_xfer) begin
            pkt_out_d       = granted_pkt;
            pkt_out_d.valid = 1'b1;
        end else if (out_xfer) begin
            pkt_out_d.valid = 1'b0;
        end
        pkt_count_d = out_xfer ? pkt_count_q + 32'd1 : pkt_count_q;
    end

    always_comb begin
        in_ready = '0;
        if ((state_q == GRANT) && can_accept) begin
            in_ready[grant_id_q] = 1'b1;
        end
        busy = (state_q == GRANT) || pkt_out_q.valid;
    end

    assign pkt_out   = pkt_out_q;
    assign grant_id  = grant_id_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_internal_arbiter.sv
// Directed bench for internal_arbiter: arbitration order, bursts, stalls, drain, reset and counter wrap.
module tb_internal_arbiter;
    import internal_pkg::*;

    localparam int NP = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    t_if_internal [NP-1:0]  pkt_in;
    logic [NP-1:0]          in_ready;
    t_if_internal           pkt_out;
    logic                   out_ready;
    logic [1:0]             grant_id;
    logic                   busy;
    logic [31:0]            pkt_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] rx_q[$];
    logic [63:0] next_data;
    logic        acc;
    logic        ox;
    logic [63:0] od;

    internal_arbiter #(
        .N_PORTS   (NP),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pkt_in    (pkt_in),
        .in_ready  (in_ready),
        .pkt_out   (pkt_out),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        pkt_in    = '0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and a single beat from port 2
        reset     = 1'b0;
        pkt_in    = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_valid",     64'(pkt_out.valid), 64'd0);
        chk("rst_data",      pkt_out.data,       64'd0);
        chk("rst_in_ready",  64'(in_ready),      64'd0);
        chk("rst_grant_id",  64'(grant_id),      64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        chk("rst_pkt_count", 64'(pkt_count),     64'd0);
        reset = 1'b1;
        pkt_in[2].valid = 1'b1;
        pkt_in[2].data  = 64'h55;
        pkt_in[2].addr  = 16'd7;
        #1;
        chk("s1_idle_ready", 64'(in_ready), 64'd0);
        step();
        chk("s1_ready",      64'(in_ready), 64'b0100);
        chk("s1_grant_id",   64'(grant_id), 64'd2);
        chk("s1_busy",       64'(busy),     64'd1);
        step();
        pkt_in[2].valid = 1'b0;
        #1;
        chk("s1_out_valid",  64'(pkt_out.valid), 64'd1);
        chk("s1_out_data",   pkt_out.data,        64'h55);
        chk("s1_out_addr",   64'(pkt_out.addr),   64'd7);
        chk("s1_count_pre",  64'(pkt_count),      64'd0);
        step();
        chk("s1_count",      64'(pkt_count),      64'd1);
        chk("s1_out_clear",  64'(pkt_out.valid),  64'd0);
        chk("s1_idle_again", 64'(in_ready),       64'd0);
        chk("s1_not_busy",   64'(busy),           64'd0);

        // All ports valid: 0,1,2,3,0 with 4 beats each
        do_reset();
        for (int p = 0; p < NP; p++) begin
            pkt_in[p].valid = 1'b1;
            pkt_in[p].data  = 64'hA0 + 64'(p);
            pkt_in[p].addr  = 16'(p);
        end
        #1;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("s2_grant_id", 64'(grant_id), 64'(g % 4));
            if (g == 4) begin
                chk("s2_pkt_count", 64'(pkt_count), 64'd16);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    chk("s2_burst_ready", 64'(in_ready), 64'(1 << g));
                    step();
                    chk("s2_beat_data", pkt_out.data, 64'hA0 + 64'(g));
                end
                chk("s2_arb_gap", 64'(in_ready), 64'd0);
            end
        end

        // Port 1 streams 1..8 with a 5-cycle output stall after beat 2
        do_reset();
        rx_q.delete();
        next_data       = 64'd1;
        pkt_in[1].valid = 1'b1;
        pkt_in[1].data  = next_data;
        pkt_in[1].addr  = 16'h11;
        #1;
        for (int c = 1; c <= 30; c++) begin
            acc = in_ready[1] && pkt_in[1].valid;
            ox  = pkt_out.valid && out_ready;
            od  = pkt_out.data;
            step();
            if (acc) begin
                next_data       = next_data + 64'd1;
                pkt_in[1].data  = next_data;
                pkt_in[1].valid = (next_data <= 64'd8);
            end
            if (ox) rx_q.push_back(od);
            out_ready = !(c >= 3 && c <= 7);
            #1;
            if (!out_ready) begin
                chk("s3_stall_ready", 64'(in_ready[1]),   64'd0);
                chk("s3_stall_valid", 64'(pkt_out.valid), 64'd1);
                chk("s3_stall_data",  pkt_out.data,       64'd2);
            end
        end
        chk("s3_rx_count", 64'(rx_q.size()), 64'd8);
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            chk("s3_rx_order", rx_q[i], 64'(i + 1));
        end

        // Port 3 drains after 2 beats; port 0 then wins over port 3
        do_reset();
        out_ready       = 1'b1;
        pkt_in[3].valid = 1'b1;
        pkt_in[3].data  = 64'h31;
        pkt_in[3].addr  = 16'd3;
        #1;
        step();
        chk("s4_grant_id", 64'(grant_id), 64'd3);
        step();
        pkt_in[3].data = 64'h32;
        step();
        pkt_in[3].valid = 1'b0;
        #1;
        chk("s4_drain_ready", 64'(in_ready), 64'b1000);
        step();
        chk("s4_idle_ready", 64'(in_ready),  64'd0);
        chk("s4_last_grant", 64'(grant_id),  64'd3);
        chk("s4_busy",       64'(busy),      64'd0);
        chk("s4_pkt_count",  64'(pkt_count), 64'd2);
        pkt_in[0].valid = 1'b1;
        pkt_in[0].data  = 64'h01;
        pkt_in[3].valid = 1'b1;
        #1;
        step();
        chk("s4_next_grant", 64'(grant_id), 64'd0);
        chk("s4_next_ready", 64'(in_ready), 64'b0001);

        // Asynchronous reset while a beat is held in pkt_out
        do_reset();
        pkt_in[2].valid = 1'b1;
        pkt_in[2].data  = 64'h77;
        pkt_in[2].addr  = 16'd9;
        #1;
        step();
        step();
        step();
        chk("s5_pre_valid", 64'(pkt_out.valid), 64'd1);
        chk("s5_pre_count", 64'(pkt_count),     64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("s5_async_valid", 64'(pkt_out.valid), 64'd0);
        chk("s5_async_data",  pkt_out.data,        64'd0);
        chk("s5_async_addr",  64'(pkt_out.addr),   64'd0);
        chk("s5_async_ready", 64'(in_ready),       64'd0);
        chk("s5_async_grant", 64'(grant_id),       64'd0);
        chk("s5_async_busy",  64'(busy),           64'd0);
        chk("s5_async_count", 64'(pkt_count),      64'd0);
        step();
        pkt_in[0].valid = 1'b1;
        pkt_in[0].data  = 64'h70;
        reset = 1'b1;
        #1;
        step();
        chk("s5_first_grant", 64'(grant_id), 64'd0);
        chk("s5_first_ready", 64'(in_ready), 64'b0001);

        // pkt_count wrap from all-ones
        do_reset();
        #1;
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_q;
        #1;
        chk("s6_preload", 64'(pkt_count), 64'hFFFF_FFFF);
        pkt_in[1].valid = 1'b1;
        pkt_in[1].data  = 64'h9;
        #1;
        step();
        step();
        pkt_in[1].valid = 1'b0;
        chk("s6_before_wrap", 64'(pkt_count), 64'hFFFF_FFFF);
        step();
        chk("s6_wrap", 64'(pkt_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
